// File: rtl/cla_serial_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // claadder numbers its nibble ports MSB-first ([0:3], index 0 = MSB);
  // our datapath is LSB-first ([3:0]). These two helpers make the
  // index reversal explicit at the boundary.
  function automatic logic [0:NIBBLE_W-1] to_cla_order(input logic [NIBBLE_W-1:0] nib);
    logic [0:NIBBLE_W-1] r;
    for (int i = 0; i < NIBBLE_W; i++) begin
      r[i] = nib[NIBBLE_W-1-i];
    end
    return r;
  endfunction

  function automatic logic [NIBBLE_W-1:0] from_cla_order(input logic [0:NIBBLE_W-1] nib);
    logic [NIBBLE_W-1:0] r;
    for (int k = 0; k < NIBBLE_W; k++) begin
      r[k] = nib[NIBBLE_W-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/claadder.sv
// 4-bit carry-lookahead adder slice; nibble ports are [0:3] with index 0 = MSB.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module claadder (
  input  logic [0:3] A,
  input  logic [0:3] B,
  input  logic       c0,
  output logic [0:3] SUM,
  output logic       Carry
);

  // g/p/c are indexed by bit weight (0 = LSB), i.e. port index 3-k
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms, lookahead carries and sum bits
  always_comb begin
    g = '0;
    p = '0;
    c = '0;
    SUM = '0;
    for (int k = 0; k < 4; k++) begin
      g[k] = A[3-k] & B[3-k];
      p[k] = A[3-k] ^ B[3-k];
    end
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    for (int k = 0; k < 4; k++) begin
      SUM[3-k] = p[k] ^ c[k];
    end
  end

  assign Carry = c[4];

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-precision adder: streams WIDTH-bit operands LSB nibble first through one claadder.
// Latency: out_valid NIBBLES edges after accept; one op per NIBBLES+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Option: CLA_SERIAL_OVF_DETECT_EN adds ovf.
module cla_serial_adder
  import cla_serial_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SERIAL_OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int          CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic                 live_q;
  logic [WIDTH-1:0]     a_sh_q;
  logic [WIDTH-1:0]     b_sh_q;
  logic [WIDTH-1:0]     sum_q;
  logic                 carry_q;
  logic                 cout_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 accept;
  logic [0:NIBBLE_W-1]  cla_sum;
  logic                 cla_carry;
  logic [NIBBLE_W-1:0]  sum_nib;
`ifdef CLA_SERIAL_OVF_DETECT_EN
  logic [1:0]           msb_q;
  logic                 ovf_q;
`endif

  assign accept  = in_valid & in_ready;
  assign sum_nib = from_cla_order(cla_sum);

  claadder O_cla (
    .A     (to_cla_order(a_sh_q[NIBBLE_W-1:0])),
    .B     (to_cla_order(b_sh_q[NIBBLE_W-1:0])),
    .c0    (carry_q),
    .SUM   (cla_sum),
    .Carry (cla_carry)
  );

  // State register; also a flag that keeps in_ready low while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state: accept -> RUN, last nibble -> DONE, result taken -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == LAST_NIB) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE) && live_q;
    out_valid = (state_q == DONE);
  end

  // Datapath: capture at accept, then one nibble per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef CLA_SERIAL_OVF_DETECT_EN
      msb_q   <= '0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
`ifdef CLA_SERIAL_OVF_DETECT_EN
            msb_q   <= {a[WIDTH-1], b[WIDTH-1]};
`endif
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> NIBBLE_W;
          b_sh_q  <= b_sh_q >> NIBBLE_W;
          sum_q   <= {sum_nib, sum_q[WIDTH-1:NIBBLE_W]};
          carry_q <= cla_carry;
          if (cnt_q == LAST_NIB) begin
            cout_q <= cla_carry;
`ifdef CLA_SERIAL_OVF_DETECT_EN
            // carry into the MSB is a^b^sum at that bit; xor with carry out
            ovf_q  <= msb_q[1] ^ msb_q[0] ^ sum_nib[NIBBLE_W-1] ^ cla_carry;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef CLA_SERIAL_OVF_DETECT_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboarded bench for cla_serial_adder (NIBBLES=4) with directed vectors.
// Latency: checks out_valid rise NIBBLES edges after accept and 6-cycle back-to-back spacing.
// Backpressure: holds out_ready low with a pending request; ovf checked when CLA_SERIAL_OVF_DETECT_EN is defined.
module tb_cla_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_SERIAL_OVF_DETECT_EN
  logic         ovf;
`endif

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  cla_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_SERIAL_OVF_DETECT_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Present operands, wait (bounded) for the accept edge, optionally push expectation.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W-1:0] es, input logic ec, input logic eo,
                      input bit push, input bit hold, output int acc);
    int n;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    acc = -1;
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    if (push) q.push_back('{sum: es, cout: ec, ovf: eo, acc_cyc: acc});
    if (!hold) in_valid = 1'b0;
  endtask

  // Monitor: compare every completed output transfer against the scoreboard
  initial begin
    logic ov_prev;
    int   rise_cyc;
    exp_t e;
    ov_prev  = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sum", {16'd0, sum}, {16'd0, e.sum});
          chk("cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef CLA_SERIAL_OVF_DETECT_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
          chk("latency", rise_cyc - e.acc_cyc, NIB);
        end
      end
    end
  end

  initial begin
    int acc0, acc1, acc2, n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic arithmetic with full carry ripple cases
    out_ready = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, acc0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, acc0);
    send(16'h9999, 16'h6666, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, acc0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, acc0);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, acc0);
    send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0, acc0);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, acc0);

    // Reset mid-RUN: the aborted op must leave nothing behind
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("pre_rst_cout", {31'd0, cout}, 32'd1);
    send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, acc0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun_sum", {16'd0, sum}, 32'd0);
    chk("midrun_cout", {31'd0, cout}, 32'd0);
    chk("midrun_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rerun_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h000A, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b0, acc0);

    // Backpressure: result held, pending request refused
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b1, 1'b0, acc0);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_sum", {16'd0, sum}, 32'h0000BCDE);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_sum", {16'd0, sum}, 32'h0000BCDE);
    send(16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b1, 1'b0, acc0);
    chk("bp_accept_next_edge", acc0 - cyc, 0);

    // Back-to-back with in_valid held high
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b1, acc0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, acc1);
    send(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0, acc2);
    chk("b2b_spacing_1", acc1 - acc0, 6);
    chk("b2b_spacing_2", acc2 - acc1, 6);

    // Drain scoreboard
    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
